// File: rtl/pc_ras_unit.sv
// Fetch PC register with stall, sticky halt and a circular return-address stack; all outputs are
// registered (1-cycle redirect latency), except pcPlus_po. Stall holds PC and RAS. Once halted,
// only reset releases the unit.
module pc_ras_unit #(
  parameter int unsigned ADDR_W               = 32,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0,
  parameter int unsigned INSTR_BYTES          = 4,
  parameter int unsigned RAS_DEPTH            = 4
) (
  input  logic                           clk_pi,
  input  logic                           reset_pi,
  input  logic                           stall_pi,
  input  logic                           halt_pi,
  input  logic                           isTakenBranch_pi,
  input  logic [ADDR_W-1:0]              targetPC_pi,
  input  logic                           isCall_pi,
  input  logic                           isReturn_pi,
  output logic [ADDR_W-1:0]              pc_po,
  output logic [ADDR_W-1:0]              pcPlus_po,
  output logic                           halted_po,
  output logic [ADDR_W-1:0]              rasTop_po,
  output logic [$clog2(RAS_DEPTH):0]     rasCount_po,
  output logic                           rasOverflow_po,
  output logic                           rasMismatch_po
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pcReg;
  logic              haltedReg;
  logic [ADDR_W-1:0] rasMem [RAS_DEPTH];
  logic [PTR_W-1:0]  topPtr;
  logic [CNT_W-1:0]  rasCount;
  logic              overflowReg;
  logic              mismatchReg;

  logic [ADDR_W-1:0] nextPc;
  logic [ADDR_W-1:0] topEntry;
  logic [PTR_W-1:0]  pushPtr;
  logic [PTR_W-1:0]  popPtr;
  logic              rasEmpty;
  logic              rasFull;
  logic              doPush;
  logic              doPop;
  logic              doReplace;
  logic              active;

  assign pcPlus_po = pcReg + ADDR_W'(INSTR_BYTES);
  assign nextPc    = isTakenBranch_pi ? targetPC_pi : pcPlus_po;

  assign rasEmpty = (rasCount == '0);
  assign rasFull  = (rasCount == CNT_W'(RAS_DEPTH));
  assign topEntry = rasEmpty ? '0 : rasMem[topPtr];
  // Power-of-two depth lets the pointer wrap naturally; when full, pushPtr lands on the oldest entry.
  assign pushPtr  = topPtr + PTR_W'(1);
  assign popPtr   = topPtr - PTR_W'(1);

  assign active    = !haltedReg && !stall_pi && !halt_pi;
  // JALR used as a return replaces the top in place; on an empty stack it degrades to a push.
  assign doPush    = isCall_pi && (!isReturn_pi || rasEmpty);
  assign doReplace = isCall_pi && isReturn_pi && !rasEmpty;
  assign doPop     = isReturn_pi && !isCall_pi && !rasEmpty;

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      pcReg       <= RESET_PC;
      haltedReg   <= 1'b0;
      topPtr      <= '0;
      rasCount    <= '0;
      overflowReg <= 1'b0;
      mismatchReg <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        rasMem[i] <= '0;
      end
    end else begin
      mismatchReg <= 1'b0;
      if (!haltedReg && !stall_pi && halt_pi) begin
        haltedReg <= 1'b1;
      end
      if (active) begin
        pcReg <= nextPc;
        if (doPush) begin
          rasMem[pushPtr] <= pcPlus_po;
          topPtr          <= pushPtr;
          if (rasFull) begin
            overflowReg <= 1'b1;
          end else begin
            rasCount <= rasCount + CNT_W'(1);
          end
        end
        if (doReplace) begin
          rasMem[topPtr] <= pcPlus_po;
        end
        if (doPop) begin
          topPtr   <= popPtr;
          rasCount <= rasCount - CNT_W'(1);
        end
        if ((doPop || doReplace) && (topEntry != targetPC_pi)) begin
          mismatchReg <= 1'b1;
        end
      end
    end
  end

  assign pc_po          = pcReg;
  assign halted_po      = haltedReg;
  assign rasTop_po      = topEntry;
  assign rasCount_po    = rasCount;
  assign rasOverflow_po = overflowReg;
  assign rasMismatch_po = mismatchReg;

endmodule

// File: doc/pc_ras_unit.md
# pc_ras_unit

Parametrised program-counter unit for the next-generation DLX core: it replaces the fixed 32-bit PC register. It adds stall and a sticky halt, and carries a circular return-address stack (RAS) that tracks call/return nesting and flags return-target mismatches. It sits between branch resolution (target and taken inputs) and instruction memory (`pc_po`). It works in the current single-cycle core and is the fetch-stage PC source for the planned pipelined core.

## Interface
Parameters:
- `ADDR_W`, 32: PC and target width in bits.
- `RESET_PC`, 0: PC value loaded on reset.
- `INSTR_BYTES`, 4: sequential PC increment.
- `RAS_DEPTH`, 4: number of RAS entries; power of two, ≥2.

Ports:
- `clk_pi`  in  1  single clock; all state changes on the rising edge.
- `reset_pi`  in  1  reset; synchronous, active-high.
- `stall_pi`  in  1  hold PC and RAS this cycle.
- `halt_pi`  in  1  current instruction is HALT.
- `isTakenBranch_pi`  in  1  redirect the PC to `targetPC_pi`.
- `targetPC_pi`  in  ADDR_W  resolved branch/jump target.
- `isCall_pi`  in  1  current instruction is JAL/JALR; push return address.
- `isReturn_pi`  in  1  current instruction is a register-indirect return (JR); pop.
- `pc_po`  out  ADDR_W  current PC.
- `pcPlus_po`  out  ADDR_W  `pc_po + INSTR_BYTES` (combinational from `pc_po`), link value.
- `halted_po`  out  1  core halted (sticky).
- `rasTop_po`  out  ADDR_W  top RAS entry; 0 when empty.
- `rasCount_po`  out  clog2(RAS_DEPTH)+1  valid RAS entries.
- `rasOverflow_po`  out  1  sticky: a push occurred while the RAS was full.
- `rasMismatch_po`  out  1  one-cycle pulse: last pop disagreed with the resolved target.

## Operation
- Cycle priority, highest first: reset, halted, stall, halt_pi, normal update.
- Reset:
  - `pc_po`=RESET_PC; `halted_po`=0; `rasCount_po`=0; `rasTop_po`=0.
  - `rasOverflow_po`=0; `rasMismatch_po`=0.
  - All RAS entries cleared to 0.
  - Reset mid-operation discards all state immediately.
- Halted (`halted_po`=1):
  - PC and RAS frozen; all request inputs ignored.
  - `rasMismatch_po`=0.
  - Only reset clears it.
- Stall (`stall_pi`=1): PC, RAS, `halted_po` unchanged; `halt_pi`, call and return ignored; `rasMismatch_po` drops to 0.
- `halt_pi`=1, not stalled: PC holds; `halted_po` set on this edge; RAS unchanged.
- Normal update, next PC:
  - `targetPC_pi` if `isTakenBranch_pi`, else `pc_po + INSTR_BYTES`.
  - Modulo 2^ADDR_W; wrap from the top address to low addresses is silent.
- The architectural next PC never comes from the RAS; the RAS is a tracker/predictor for the pipelined core.
- RAS operations, when not stalled and not halted:
  - Push (call only): entry = `pcPlus_po`; count+1.
  - Push when full: overwrite the oldest entry (circular); count stays RAS_DEPTH; `rasOverflow_po` set.
  - Pop (return only), count>0: count−1. If the popped value ≠ `targetPC_pi`, `rasMismatch_po`=1 next cycle.
  - Pop when empty: no change; no mismatch pulse.
  - Call and return together (JALR used as return): top replaced with `pcPlus_po`; count unchanged. If empty, treat as a plain push. The mismatch check still compares the old top against `targetPC_pi`.
- Implement the RAS as a circular buffer with a top pointer modulo RAS_DEPTH plus a saturating count.

## Timing
- All outputs except `pcPlus_po` are registered. Inputs sampled on edge N take effect on `pc_po`, RAS outputs and `halted_po` after edge N.
- Redirect latency: 1 cycle; no bubble.
- `rasMismatch_po` is high exactly for the cycle following the offending pop.
- `rasTop_po` reflects the post-edge stack.
- Combinational paths: `pcPlus_po` from `pc_po` only. No input-to-output combinational path.

## Test plan
- Reset, then 3 free-running cycles, RESET_PC=0 → `pc_po` 0, 4, 8, 12; all flags 0.
- Taken branch to 0x100 at PC 8, then `stall_pi` for 2 cycles → `pc_po` 0x100 held 2 cycles, then 0x104. Wrap: PC 0xFFFFFFFC non-taken → 0.
- Calls at PCs 0x10, 0x20, 0x30, 0x40, 0x50 (DEPTH=4) → count saturates at 4; `rasOverflow_po`=1; `rasTop_po`=0x54. Four returns with matching targets → tops 0x44, 0x34, 0x24, then count 0; no mismatch.
- Return with target 0x200 while top=0x14 → `pc_po`=0x200, `rasMismatch_po` high exactly one cycle. Return on empty stack → no pulse.
- Simultaneous call+return at PC 0x60 with count 2 → count stays 2; top=0x64.
- `halt_pi` at PC 0x30 → `halted_po`=1, PC frozen at 0x30 despite branch/call inputs. Assert reset mid-halt → all outputs return to reset values next edge.
